// File: rtl/gx400_color_ram_reader.sv
// Palette stage: 2048x16 color RAM shared between video lookup (on i_CEN6) and a byte-wide CPU port.
// Optional CPU readback is enabled by defining GX400_COLOR_RAM_CPU_READ_EN.
module gx400_color_ram_reader (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_CEN6,
  input  logic [10:0] i_COLOR_RAM_ADDR,
  input  logic        i_BLANK_n,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WE,
  input  logic [11:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DIN,
  output logic [7:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic [4:0]  o_R,
  output logic [4:0]  o_G,
  output logic [4:0]  o_B
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        cpu_go;
  logic [10:0] cpu_idx;
  logic        cpu_hi;
  logic [15:0] ram [2048];
  logic [14:0] vid_word_q;
  logic        blank_q;
  logic [4:0]  r_q, g_q, b_q;

  assign cpu_idx = i_CPU_ADDR[11:1];
  assign cpu_hi  = ~i_CPU_ADDR[0];

  // CPU only touches the RAM in clocks the video path leaves free
  always_comb begin
    state_d = state_q;
    cpu_go  = 1'b0;
    case (state_q)
      S_IDLE: if (i_CPU_REQ && !i_CEN6) begin
        cpu_go  = 1'b1;
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign o_CPU_ACK = (state_q == S_ACK);

  always_ff @(posedge i_CLK) begin
    if (!i_RST && cpu_go && i_CPU_WE) begin
      if (cpu_hi) ram[cpu_idx][15:8] <= i_CPU_DIN;
      else        ram[cpu_idx][7:0]  <= i_CPU_DIN;
    end
  end

  // Word fetched at pixel k is shown at pixel k+1
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      vid_word_q <= '0;
      blank_q    <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else if (i_CEN6) begin
      {b_q, g_q, r_q} <= blank_q ? vid_word_q : 15'd0;
      vid_word_q      <= ram[i_COLOR_RAM_ADDR][14:0];
      blank_q         <= i_BLANK_n;
    end
  end

  assign o_R = r_q;
  assign o_G = g_q;
  assign o_B = b_q;

`ifdef GX400_COLOR_RAM_CPU_READ_EN
  logic [7:0] dout_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST)                      dout_q <= '0;
    else if (cpu_go && !i_CPU_WE)   dout_q <= cpu_hi ? ram[cpu_idx][15:8] : ram[cpu_idx][7:0];
  end

  assign o_CPU_DOUT = dout_q;
`else
  assign o_CPU_DOUT = 8'h00;
`endif

endmodule
